ca: RTL and testbench
=====================

# ca

Parameterised carry-lookahead carry generator that produces the unsigned carry-out of `A + B + C_in` for n-bit operands. It sits in the Barrett modular-multiplication datapath, where it supplies the carry/borrow decision for the reduction and compare steps without building a full-width adder. The result is registered, with a simple valid strobe.

## Interface
- `n`, default 4: operand width in bits; legal range 2..64.
- `GROUP`, default 4: lookahead group size in bits. If `GROUP` does not divide `n`, the last group is partial.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `A` input n: operand A, treated as unsigned for carry purposes.
- `B` input n: operand B, treated as unsigned.
- `C_in` input 1: carry into bit 0.
- `in_valid` input 1: operands are sampled when this is high on a rising edge.
- `C_out` output 1: registered carry out of bit n-1.
- `out_valid` output 1: registered; high for one cycle per accepted operand set.

## Operation
- Per-bit signals: g[i] = A[i] & B[i]; p[i] = A[i] ^ B[i].
- Group stage:
  - G = g[msb] | p[msb]&g[msb-1] | … ; P = AND of the group's p bits.
  - Each group's carry-out is G | P & c_group_in.
  - Groups are chained through a second lookahead level.
  - The chain must not ripple across all n bits.
- Required result: C_out = bit n of the zero-extended sum {1'b0,A} + {1'b0,B} + C_in.
  - Operand signedness is ignored.
  - A signed caller wanting overflow must derive it separately.
- When `in_valid` is high at a rising edge (and `rst` is low): C_out and out_valid are loaded with the computed carry and 1 respectively.
- When `in_valid` is low: out_valid is loaded with 0 and C_out holds its last value.
- No backpressure: every accepted input produces exactly one output.

## Timing
- Latency: exactly 1 clock, from the sampling edge to the edge where C_out/out_valid update.
- Throughput: one operand set per cycle; back-to-back `in_valid` is supported.
- Reset values: C_out = 0, out_valid = 0 (and sum = 0 when configured in).
- Reset takes priority over `in_valid` on the same edge; that input is dropped.
- Reset asserted mid-stream: the next cycle shows out_valid = 0, and no stale result appears after reset is released.
- The combinational path from A/B/C_in to the output register is at most about 2·log2(n) lookahead levels.

## Configuration
- Macro `CA_SUM_EN`.
- Defined:
  - Adds output port `sum` (n bits), registered alongside C_out.
  - Equals the low n bits of A + B + C_in.
  - Same latency, reset value 0, and holds when `in_valid` is low.
- Undefined:
  - No `sum` port and no sum logic.
  - C_out behaviour is identical.

## Test plan
- Exhaustive, n=4: all A, B in 0..15 and C_in ∈ {0,1}, one vector per cycle → each C_out equals bit 4 of A+B+C_in, one cycle later, with out_valid = 1.
- Carry boundary, n=4: A=4'hF, B=4'h0, C_in=1 → C_out=1; same operands with C_in=0 → C_out=0. A=4'h8, B=4'h8, C_in=0 → C_out=1.
- Reset: drive A=4'hF, B=4'hF, C_in=1, then assert `rst` on the next edge together with `in_valid` → C_out=0 and out_valid=0; after release, the first valid result appears 1 cycle after the next accepted input.
- Hold: accept A=4'hF, B=4'h1 (C_out=1), then deassert `in_valid` for 3 cycles with changing A/B → C_out stays 1 and out_valid stays 0.
- Wide and partial groups:
  - n=16, GROUP=4: A=16'hFFFF, B=16'h0000, C_in=1 → C_out=1; A=16'h7FFF, B=16'h8000, C_in=0 → C_out=0.
  - n=7, GROUP=4 with random vectors → C_out matches the reference sum.
- With `CA_SUM_EN` defined, n=4: A=4'h9, B=4'h8, C_in=1 → sum=4'h2, C_out=1.

Source files
------------

// File: rtl/ca.sv
// ca: two-level carry-lookahead carry generator for A + B + C_in.
// Bit-level g/p fold into GROUP-wide group G/P, and the group pairs are
// combined with a parallel prefix, so the carry path grows with log2 of
// the group count rather than rippling across all n bits.
// Optional macro CA_SUM_EN adds a registered n-bit sum output.
module ca #(
  parameter int unsigned n     = 4,
  parameter int unsigned GROUP = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic         C_in,
  input  logic         in_valid,
  output logic         C_out,
  output logic         out_valid
`ifdef CA_SUM_EN
  ,
  output logic [n-1:0] sum
`endif
);

  localparam int unsigned NG   = (n + GROUP - 1) / GROUP;
  localparam int unsigned PADW = NG * GROUP;
  localparam int unsigned LG   = $clog2(NG);

  logic [PADW-1:0] w_gx;
  logic [PADW-1:0] w_px;
  logic [NG-1:0]   w_gg;
  logic [NG-1:0]   w_gp;
  logic [NG-1:0]   w_pg;
  logic [NG-1:0]   w_pp;
  logic            w_cout;

  logic            r_cout;
  logic            r_valid;

  // Per-bit generate/propagate; padding bits propagate so a partial last group behaves
  always_comb begin
    w_gx         = '0;
    w_px         = '1;
    w_gx[n-1:0]  = A & B;
    w_px[n-1:0]  = A ^ B;
  end

  // Group generate/propagate for each GROUP-bit slice
  always_comb begin
    w_gg = '0;
    w_gp = '1;
    for (int k = 0; k < int'(NG); k++) begin
      for (int b = 0; b < int'(GROUP); b++) begin
        w_gg[k] = w_gx[k*int'(GROUP)+b] | (w_px[k*int'(GROUP)+b] & w_gg[k]);
        w_gp[k] = w_gp[k] & w_px[k*int'(GROUP)+b];
      end
    end
  end

  // Second-level lookahead: Kogge-Stone prefix over group (G,P) pairs
  always_comb begin
    w_pg = w_gg;
    w_pp = w_gp;
    for (int s = 0; s < int'(LG); s++) begin
      // Descending k so w_pg[k-d] still holds the previous level's value
      for (int k = int'(NG) - 1; k >= (1 << s); k--) begin
        w_pg[k] = w_pg[k] | (w_pp[k] & w_pg[k-(1<<s)]);
        w_pp[k] = w_pp[k] & w_pp[k-(1<<s)];
      end
    end
  end

  // Carry out of bit n-1: prefix over all groups applied to C_in
  always_comb begin
    w_cout = w_pg[NG-1] | (w_pp[NG-1] & C_in);
  end

  // Result register; reset wins over in_valid, C_out holds while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_cout <= w_cout;
      end
    end
  end

  assign C_out     = r_cout;
  assign out_valid = r_valid;

`ifdef CA_SUM_EN
  logic [NG-1:0]   w_cgrp;
  logic [PADW-1:0] w_sx;
  logic            w_c;
  logic [n-1:0]    r_sum;

  // Carry into each group from the prefix, then short in-group carries for the sum bits
  always_comb begin
    w_cgrp    = '0;
    w_sx      = '0;
    w_c       = 1'b0;
    w_cgrp[0] = C_in;
    for (int k = 1; k < int'(NG); k++) begin
      w_cgrp[k] = w_pg[k-1] | (w_pp[k-1] & C_in);
    end
    for (int k = 0; k < int'(NG); k++) begin
      w_c = w_cgrp[k];
      for (int b = 0; b < int'(GROUP); b++) begin
        w_sx[k*int'(GROUP)+b] = w_px[k*int'(GROUP)+b] ^ w_c;
        w_c = w_gx[k*int'(GROUP)+b] | (w_px[k*int'(GROUP)+b] & w_c);
      end
    end
  end

  // Sum register, loaded alongside C_out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
    end else if (in_valid) begin
      r_sum <= w_sx[n-1:0];
    end
  end

  assign sum = r_sum;
`endif

endmodule

// File: tb/tb_ca.sv
// tb_ca: directed checks of the ca carry generator at n=4, n=16 and n=7.
module tb_ca;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cin;
  logic        vld;
  logic [3:0]  a4, b4;
  logic [15:0] a16, b16;
  logic [6:0]  a7, b7;
  logic        co4, ov4, co16, ov16, co7, ov7;
`ifdef CA_SUM_EN
  logic [3:0]  s4;
  logic [15:0] s16;
  logic [6:0]  s7;
`endif

  int vecs = 0;
  int errs = 0;

  ca #(.n(4), .GROUP(4)) u4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .C_in(cin), .in_valid(vld),
    .C_out(co4), .out_valid(ov4)
`ifdef CA_SUM_EN
    , .sum(s4)
`endif
  );

  ca #(.n(16), .GROUP(4)) u16 (
    .clk(clk), .rst(rst), .A(a16), .B(b16), .C_in(cin), .in_valid(vld),
    .C_out(co16), .out_valid(ov16)
`ifdef CA_SUM_EN
    , .sum(s16)
`endif
  );

  ca #(.n(7), .GROUP(4)) u7 (
    .clk(clk), .rst(rst), .A(a7), .B(b7), .C_in(cin), .in_valid(vld),
    .C_out(co7), .out_valid(ov7)
`ifdef CA_SUM_EN
    , .sum(s7)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b0; cin = 1'b0;
    a4 = '0; b4 = '0; a16 = '0; b16 = '0; a7 = '0; b7 = '0;
    step();
    step();
    vecs++;
    if ({co4, ov4, co16, ov16, co7, ov7} !== 6'b0) begin
      errs++;
      $display("FAIL reset_state got %b want 000000", {co4, ov4, co16, ov16, co7, ov7});
    end
    rst = 1'b0;
  endtask

  task automatic test_exhaustive();
    logic [4:0] t;
    vld = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          a4 = 4'(a); b4 = 4'(b); cin = 1'(c);
          t = 5'(a) + 5'(b) + 5'(c);
          step();
          vecs++;
          if (co4 !== t[4] || ov4 !== 1'b1) begin
            errs++;
            $display("FAIL exhaustive a=%0h b=%0h c=%0d got co=%b ov=%b want co=%b ov=1",
                     a, b, c, co4, ov4, t[4]);
          end
`ifdef CA_SUM_EN
          vecs++;
          if (s4 !== t[3:0]) begin
            errs++;
            $display("FAIL exhaustive_sum a=%0h b=%0h c=%0d got %h want %h", a, b, c, s4, t[3:0]);
          end
`endif
        end
      end
    end
  endtask

  task automatic test_boundary();
    logic [8:0] vecs_in [3];
    logic       want [3];
    vecs_in[0] = {4'hF, 4'h0, 1'b1}; want[0] = 1'b1;
    vecs_in[1] = {4'hF, 4'h0, 1'b0}; want[1] = 1'b0;
    vecs_in[2] = {4'h8, 4'h8, 1'b0}; want[2] = 1'b1;
    vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      {a4, b4, cin} = vecs_in[i];
      step();
      vecs++;
      if (co4 !== want[i] || ov4 !== 1'b1) begin
        errs++;
        $display("FAIL boundary_%0d got co=%b ov=%b want co=%b ov=1", i, co4, ov4, want[i]);
      end
    end
  endtask

  task automatic test_hold();
    vld = 1'b1; a4 = 4'hF; b4 = 4'h1; cin = 1'b0;
    step();
    vecs++;
    if (co4 !== 1'b1 || ov4 !== 1'b1) begin
      errs++;
      $display("FAIL hold_accept got co=%b ov=%b want co=1 ov=1", co4, ov4);
    end
    vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a4 = 4'(i); b4 = 4'(i + 2);
      step();
      vecs++;
      if (co4 !== 1'b1 || ov4 !== 1'b0) begin
        errs++;
        $display("FAIL hold_%0d got co=%b ov=%b want co=1 ov=0", i, co4, ov4);
      end
    end
  endtask

  task automatic test_reset_mid();
    vld = 1'b1; a4 = 4'hF; b4 = 4'hF; cin = 1'b1;
    step();
    vecs++;
    if (co4 !== 1'b1 || ov4 !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_pre got co=%b ov=%b want co=1 ov=1", co4, ov4);
    end
    rst = 1'b1;
    step();
    vecs++;
    if (co4 !== 1'b0 || ov4 !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_drop got co=%b ov=%b want co=0 ov=0", co4, ov4);
    end
    rst = 1'b0; vld = 1'b0;
    step();
    vecs++;
    if (co4 !== 1'b0 || ov4 !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_stale got co=%b ov=%b want co=0 ov=0", co4, ov4);
    end
    vld = 1'b1; a4 = 4'hF; b4 = 4'h1; cin = 1'b0;
    step();
    vecs++;
    if (co4 !== 1'b1 || ov4 !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_first got co=%b ov=%b want co=1 ov=1", co4, ov4);
    end
    vld = 1'b0;
    step();
  endtask

  task automatic test_back_to_back_wide();
    vld = 1'b1; a16 = 16'hFFFF; b16 = 16'h0000; cin = 1'b1;
    step();
    vecs++;
    if (co16 !== 1'b1 || ov16 !== 1'b1) begin
      errs++;
      $display("FAIL wide_ffff got co=%b ov=%b want co=1 ov=1", co16, ov16);
    end
    a16 = 16'h7FFF; b16 = 16'h8000; cin = 1'b0;
    step();
    vecs++;
    if (co16 !== 1'b0 || ov16 !== 1'b1) begin
      errs++;
      $display("FAIL wide_7fff got co=%b ov=%b want co=0 ov=1", co16, ov16);
    end
    a16 = 16'h7FFF; b16 = 16'h8000; cin = 1'b1;
    step();
    vecs++;
    if (co16 !== 1'b1) begin
      errs++;
      $display("FAIL wide_7fff_c1 got co=%b want 1", co16);
    end
    a16 = 16'h00F0; b16 = 16'h0F10; cin = 1'b0;
    step();
    vecs++;
    if (co16 !== 1'b0) begin
      errs++;
      $display("FAIL wide_small got co=%b want 0", co16);
    end
    vld = 1'b0;
  endtask

  task automatic test_partial_group();
    logic [7:0] t;
    vld = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 0) begin
        a7 = 7'h7F; b7 = 7'h00; cin = 1'b1;
      end else if (i == 1) begin
        a7 = 7'h40; b7 = 7'h40; cin = 1'b0;
      end else if (i == 2) begin
        a7 = 7'h7F; b7 = 7'h00; cin = 1'b0;
      end else begin
        a7 = 7'($urandom); b7 = 7'($urandom); cin = 1'($urandom);
      end
      t = 8'(a7) + 8'(b7) + 8'(cin);
      step();
      vecs++;
      if (co7 !== t[7] || ov7 !== 1'b1) begin
        errs++;
        $display("FAIL partial a=%0h b=%0h c=%0d got co=%b ov=%b want co=%b ov=1",
                 a7, b7, cin, co7, ov7, t[7]);
      end
`ifdef CA_SUM_EN
      vecs++;
      if (s7 !== t[6:0]) begin
        errs++;
        $display("FAIL partial_sum got %h want %h", s7, t[6:0]);
      end
`endif
    end
    vld = 1'b0;
  endtask

`ifdef CA_SUM_EN
  task automatic test_sum();
    vld = 1'b1; a4 = 4'h9; b4 = 4'h8; cin = 1'b1;
    step();
    vecs++;
    if (s4 !== 4'h2 || co4 !== 1'b1) begin
      errs++;
      $display("FAIL sum got sum=%h co=%b want sum=2 co=1", s4, co4);
    end
    vld = 1'b0; a4 = 4'h0;
    step();
    vecs++;
    if (s4 !== 4'h2) begin
      errs++;
      $display("FAIL sum_hold got %h want 2", s4);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_exhaustive();
    test_boundary();
    test_hold();
    test_reset_mid();
    test_back_to_back_wide();
    test_partial_group();
`ifdef CA_SUM_EN
    test_sum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
